mmio_route_ctrl: RTL and testbench

- Registered successor to the combinational uncached/cached request splitter in the LSU data path.
- Routes each core load/store either to the uncached arbiter port (MMIO) or to the dcache port.
- The MMIO region set is parametrised (count, bounds, read-only attribute).
- Holds a latched request stable until the target finishes; adds a timeout on MMIO accesses and an error response.

---
 rtl/mmio_pkg.sv | 26 ++
 rtl/mmio_region_decode.sv | 29 ++
 rtl/mmio_route_ctrl.sv | 157 +++++++++++++++
 tb/tb_mmio_route_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO/dcache request router.
package mmio_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCache,
    StUncache,
    StResp
  } state_e;

  localparam logic [63:0] SerialBase = 64'ha00003f8;
  localparam logic [63:0] SerialEnd  = 64'ha00003ff;
  localparam logic [63:0] RtcBase    = 64'ha0000048;
  localparam logic [63:0] RtcEnd     = 64'ha000004f;

  localparam logic [63:0] ErrData = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [63:0] expand_mask(input logic [7:0] mask);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[8*i +: 8] = {8{mask[i]}};
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_region_decode.sv
// Combinational uncached-region lookup: one-hot hit vector plus the read-only attribute
// of the hit region. Overlapping regions resolve to the lowest index.
module mmio_region_decode
  import mmio_pkg::*;
#(
  parameter int unsigned               NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*64-1:0] REGION_BASE = {RtcBase, SerialBase},
  parameter logic [NUM_REGIONS*64-1:0] REGION_END  = {RtcEnd, SerialEnd},
  parameter logic [NUM_REGIONS-1:0]    REGION_RO   = 2'b10
) (
  input  logic [63:0]            addr,
  output logic [NUM_REGIONS-1:0] hit,
  output logic                   ro
);

  always_comb begin
    hit = '0;
    ro  = 1'b0;
    // Walk downwards so the last match written is the lowest index.
    for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
      if (addr >= REGION_BASE[i*64 +: 64] && addr <= REGION_END[i*64 +: 64]) begin
        hit    = '0;
        hit[i] = 1'b1;
        ro     = REGION_RO[i];
      end
    end
  end

endmodule

// File: rtl/mmio_route_ctrl.sv
// Registered LSU request router: steers each core load/store to the uncached arbiter (MMIO)
// or the dcache, holds it until the target finishes, and times out stalled MMIO accesses.
module mmio_route_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned               NUM_REGIONS    = 2,
  parameter logic [NUM_REGIONS*64-1:0] REGION_BASE    = {RtcBase, SerialBase},
  parameter logic [NUM_REGIONS*64-1:0] REGION_END     = {RtcEnd, SerialEnd},
  parameter logic [NUM_REGIONS-1:0]    REGION_RO      = 2'b10,
  parameter int unsigned               TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic [63:0]            core_addr,
  input  logic [63:0]            core_data,
  input  logic [7:0]             core_mask,
  input  logic                   core_we,
  input  logic                   core_re,
  output logic [63:0]            in_core_data,
  output logic                   in_core_finish,
  output logic [NUM_REGIONS:0]   mmio_sign,
  output logic                   mmio_err,

  output logic [63:0]            arb_addr,
  output logic [63:0]            arb_data,
  output logic [7:0]             arb_mask,
  output logic                   arb_we,
  output logic                   arb_re,
  input  logic [63:0]            in_arb_data,
  input  logic                   in_arb_finish,

  output logic [63:0]            dcache_addr,
  output logic [63:0]            dcache_data,
  output logic [7:0]             dcache_mask,
  output logic                   dcache_we,
  output logic                   dcache_re,
  input  logic [63:0]            in_dcache_data,
  input  logic                   in_dcache_finish
);

  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [NUM_REGIONS-1:0] hit;
  logic                   ro_hit;

  mmio_region_decode #(
    .NUM_REGIONS(NUM_REGIONS),
    .REGION_BASE(REGION_BASE),
    .REGION_END (REGION_END),
    .REGION_RO  (REGION_RO)
  ) u_decode (
    .addr(core_addr),
    .hit (hit),
    .ro  (ro_hit)
  );

  // The port output registers double as the request latches; an idle port reads all-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      in_core_data   <= '0;
      in_core_finish <= 1'b0;
      mmio_sign      <= '0;
      mmio_err       <= 1'b0;
      arb_addr       <= '0;
      arb_data       <= '0;
      arb_mask       <= '0;
      arb_we         <= 1'b0;
      arb_re         <= 1'b0;
      dcache_addr    <= '0;
      dcache_data    <= '0;
      dcache_mask    <= '0;
      dcache_we      <= 1'b0;
      dcache_re      <= 1'b0;
    end else begin
      in_core_finish <= 1'b0;
      mmio_err       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          in_core_data <= '0;
          mmio_sign    <= '0;
          cnt_q        <= '0;
          if (core_we || core_re) begin
            if (|hit) begin
              mmio_sign <= {1'b0, hit};
              if (ro_hit && core_we) begin
                // Write to a read-only region is refused without touching the bus.
                in_core_data   <= '0;
                in_core_finish <= 1'b1;
                mmio_err       <= 1'b1;
                state_q        <= StResp;
              end else begin
                arb_addr <= core_addr;
                arb_data <= core_data & expand_mask(core_mask);
                arb_mask <= core_mask;
                arb_we   <= core_we;
                arb_re   <= core_re & ~core_we;
                state_q  <= StUncache;
              end
            end else begin
              mmio_sign   <= {1'b1, {NUM_REGIONS{1'b0}}};
              dcache_addr <= core_addr;
              dcache_data <= core_data;
              dcache_mask <= core_mask;
              dcache_we   <= core_we;
              dcache_re   <= core_re & ~core_we;
              state_q     <= StCache;
            end
          end
        end

        StCache: begin
          if (in_dcache_finish) begin
            in_core_data   <= in_dcache_data;
            in_core_finish <= 1'b1;
            dcache_addr    <= '0;
            dcache_data    <= '0;
            dcache_mask    <= '0;
            dcache_we      <= 1'b0;
            dcache_re      <= 1'b0;
            state_q        <= StResp;
          end
        end

        StUncache: begin
          cnt_q <= cnt_q + 1'b1;
          if (in_arb_finish || cnt_q == CntLast) begin
            // A finish arriving on the expiry cycle still counts as a normal completion.
            in_core_data   <= in_arb_finish ? in_arb_data : ErrData;
            mmio_err       <= ~in_arb_finish;
            in_core_finish <= 1'b1;
            arb_addr       <= '0;
            arb_data       <= '0;
            arb_mask       <= '0;
            arb_we         <= 1'b0;
            arb_re         <= 1'b0;
            state_q        <= StResp;
          end
        end

        StResp: begin
          in_core_data <= '0;
          mmio_sign    <= '0;
          state_q      <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_route_ctrl.sv
// Self-checking bench for mmio_route_ctrl: directed and random transactions against an
// address-map / latency model, plus reset and timeout corner cases.
module tb_mmio_route_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] core_addr, core_data;
  logic [7:0]  core_mask;
  logic        core_we, core_re;
  logic [63:0] in_core_data;
  logic        in_core_finish;
  logic [2:0]  mmio_sign;
  logic        mmio_err;
  logic [63:0] arb_addr, arb_data;
  logic [7:0]  arb_mask;
  logic        arb_we, arb_re;
  logic [63:0] in_arb_data;
  logic        in_arb_finish;
  logic [63:0] dcache_addr, dcache_data;
  logic [7:0]  dcache_mask;
  logic        dcache_we, dcache_re;
  logic [63:0] in_dcache_data;
  logic        in_dcache_finish;

  int checks = 0;
  int errors = 0;

  // Address map as seen by software: index 0 serial, index 1 RTC (read-only).
  logic [63:0] reg_base[2] = '{64'ha00003f8, 64'ha0000048};
  logic [63:0] reg_end[2]  = '{64'ha00003ff, 64'ha000004f};
  bit          reg_ro[2]   = '{1'b0, 1'b1};

  logic [137:0] arb_vec, dc_vec;
  assign arb_vec = {arb_addr, arb_data, arb_mask, arb_we, arb_re};
  assign dc_vec  = {dcache_addr, dcache_data, dcache_mask, dcache_we, dcache_re};

  mmio_route_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .core_addr       (core_addr),
    .core_data       (core_data),
    .core_mask       (core_mask),
    .core_we         (core_we),
    .core_re         (core_re),
    .in_core_data    (in_core_data),
    .in_core_finish  (in_core_finish),
    .mmio_sign       (mmio_sign),
    .mmio_err        (mmio_err),
    .arb_addr        (arb_addr),
    .arb_data        (arb_data),
    .arb_mask        (arb_mask),
    .arb_we          (arb_we),
    .arb_re          (arb_re),
    .in_arb_data     (in_arb_data),
    .in_arb_finish   (in_arb_finish),
    .dcache_addr     (dcache_addr),
    .dcache_data     (dcache_data),
    .dcache_mask     (dcache_mask),
    .dcache_we       (dcache_we),
    .dcache_re       (dcache_re),
    .in_dcache_data  (in_dcache_data),
    .in_dcache_finish(in_dcache_finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int region_of(input logic [63:0] a);
    for (int i = 0; i < 2; i++) begin
      if (a >= reg_base[i] && a <= reg_end[i]) return i;
    end
    return -1;
  endfunction

  // One complete core transaction; the responder finishes 'lat' cycles after the
  // downstream request first appears (lat >= 255 on MMIO means it never answers).
  task automatic txn(input string tag, input logic [63:0] a, input logic [63:0] d,
                     input logic [7:0] m, input logic we, input logic re, input int lat);
    int           reg_i, r, exp_c, c;
    bit           ro_err, uncached, is_cache, done, held_ok;
    logic         wq, rq, exp_err;
    logic [63:0]  mx, resp, exp_data;
    logic [2:0]   exp_sign;
    logic [137:0] exp_arb, exp_dc;

    wq       = we;
    rq       = re & ~we;
    reg_i    = region_of(a);
    ro_err   = (reg_i >= 0) && reg_ro[reg_i] && we;
    uncached = (reg_i >= 0) && !ro_err;
    is_cache = (reg_i < 0);
    mx = '0;
    for (int b = 0; b < 8; b++) if (m[b]) mx[8*b +: 8] = 8'hff;
    exp_sign = is_cache ? 3'b100 : ((reg_i == 0) ? 3'b001 : 3'b010);
    resp     = {$urandom, $urandom};
    r        = 1 + lat;
    exp_arb  = uncached ? {a, d & mx, m, wq, rq} : '0;
    exp_dc   = is_cache ? {a, d, m, wq, rq} : '0;
    if (ro_err) begin
      exp_c = 1; exp_data = '0; exp_err = 1'b1;
    end else if (uncached && r > 255) begin
      exp_c = 256; exp_data = 64'hFFFF_FFFF_FFFF_FFFF; exp_err = 1'b1;
    end else begin
      exp_c = r + 1; exp_data = resp; exp_err = 1'b0;
    end

    core_addr = a; core_data = d; core_mask = m; core_we = we; core_re = re;
    @(posedge clk); #1;
    c = 1; done = 0; held_ok = 1;
    while (!done && c < 400) begin
      if (in_core_finish) begin
        done = 1;
      end else begin
        if (c == 1) begin
          chk({tag, ":arb_c1"}, 160'(arb_vec), 160'(exp_arb));
          chk({tag, ":dc_c1"}, 160'(dc_vec), 160'(exp_dc));
          chk({tag, ":sign_c1"}, 160'(mmio_sign), 160'(exp_sign));
        end
        if (arb_vec !== exp_arb || dc_vec !== exp_dc || mmio_sign !== exp_sign) held_ok = 0;
        in_arb_finish    = uncached && (c == r);
        in_arb_data      = (uncached && c == r) ? resp : ~resp;
        in_dcache_finish = is_cache && (c == r);
        in_dcache_data   = (is_cache && c == r) ? resp : ~resp;
        @(posedge clk); #1;
        c++;
      end
    end
    in_arb_finish = 1'b0;
    in_dcache_finish = 1'b0;
    chk({tag, ":finished"}, 160'(done), 160'(1));
    chk({tag, ":fin_cycle"}, 160'(c), 160'(exp_c));
    chk({tag, ":held"}, 160'(held_ok), 160'(1));
    chk({tag, ":data"}, 160'(in_core_data), 160'(exp_data));
    chk({tag, ":err"}, 160'(mmio_err), 160'(exp_err));
    chk({tag, ":sign_resp"}, 160'(mmio_sign), 160'(exp_sign));
    chk({tag, ":ports_resp"}, 160'({arb_we, arb_re, dcache_we, dcache_re}), 160'(0));
    core_we = 1'b0; core_re = 1'b0;
    @(posedge clk); #1;
    chk({tag, ":pulse_end"}, 160'({in_core_finish, mmio_err, mmio_sign}), 160'(0));
  endtask

  initial begin
    logic [63:0] a;
    logic [1:0]  op;
    rst = 1'b1;
    core_addr = '0; core_data = '0; core_mask = '0; core_we = 1'b0; core_re = 1'b0;
    in_arb_data = '0; in_arb_finish = 1'b0; in_dcache_data = '0; in_dcache_finish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:core", 160'({in_core_data, in_core_finish, mmio_err, mmio_sign}), 160'(0));
    chk("rst:arb", 160'(arb_vec), 160'(0));
    chk("rst:dc", 160'(dc_vec), 160'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    txn("cache_rd", 64'h80001000, 64'h0, 8'hff, 1'b0, 1'b1, 2);
    txn("ser_wr", 64'ha00003f8, 64'hAABBCCDDEEFF0041, 8'h01, 1'b1, 1'b0, 0);
    txn("rtc_wr_ro", 64'ha0000048, 64'h1234, 8'hff, 1'b1, 1'b0, 0);
    txn("rtc_rd_timeout", 64'ha0000048, 64'h0, 8'hff, 1'b0, 1'b1, 1000);
    txn("ser_rd_expiry_fin", 64'ha00003fc, 64'h0, 8'h0f, 1'b0, 1'b1, 254);
    txn("ser_rd_pre_expiry", 64'ha00003fd, 64'h0, 8'hff, 1'b0, 1'b1, 253);
    txn("both_we_re", 64'h80000000, 64'h0123456789abcdef, 8'hf0, 1'b1, 1'b1, 0);
    txn("ser_end_rd", 64'ha00003ff, 64'h0, 8'hff, 1'b0, 1'b1, 1);
    txn("ser_past_end", 64'ha0000400, 64'h55, 8'h3c, 1'b1, 1'b0, 1);
    txn("rtc_below", 64'ha0000047, 64'h0, 8'hff, 1'b0, 1'b1, 0);
    txn("rtc_end_wr", 64'ha000004f, 64'h77, 8'h80, 1'b1, 1'b1, 3);
    txn("rtc_past_wr", 64'ha0000050, 64'h99, 8'h11, 1'b1, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: a = reg_base[0] + 64'($urandom_range(0, 7));
        1: a = reg_base[1] + 64'($urandom_range(0, 7));
        2: a = reg_end[$urandom_range(0, 1)] + 64'($urandom_range(0, 2)) - 64'd1;
        default: a = {32'h0000_0000, 2'b10, 30'($urandom)};
      endcase
      op = 2'($urandom_range(1, 3));
      txn("rand", a, {$urandom, $urandom}, 8'($urandom), op[0], op[1], $urandom_range(0, 5));
    end

    // Reset in the middle of an uncached read, then a stray finish must be ignored.
    core_addr = 64'ha00003f8; core_data = '0; core_mask = 8'hff; core_we = 1'b0; core_re = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst:active", 160'(arb_re), 160'(1));
    rst = 1'b1; core_re = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst:arb", 160'(arb_vec), 160'(0));
    chk("mid_rst:core", 160'({in_core_data, in_core_finish, mmio_err, mmio_sign}), 160'(0));
    rst = 1'b0; in_arb_finish = 1'b1; in_arb_data = 64'hdead_beef_cafe_f00d;
    @(posedge clk); #1;
    in_arb_finish = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst:no_fin", 160'({in_core_finish, mmio_err, mmio_sign}), 160'(0));
      @(posedge clk); #1;
    end
    txn("after_rst", 64'h80002000, 64'h0, 8'hff, 1'b0, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
